// File: rtl/tage_hist.sv
// TAGE global history: circular GHR, per-bank folded index/tag histories
// and per-FTQ-entry checkpoints for one-cycle redirect recovery.
module tage_hist #(
  parameter int BANK_NUM = 4,
  parameter int HIST_LEN [BANK_NUM] = '{8, 16, 32, 64},
  parameter int IDX_W    = 8,
  parameter int GHR_SIZE = 128,
  parameter int CKPT_NUM = 16,
  localparam int T1W = 12,
  localparam int T2W = 10,
  localparam int PW  = $clog2(GHR_SIZE),
  localparam int CW  = $clog2(CKPT_NUM),
  localparam int IW  = BANK_NUM * IDX_W,
  localparam int AW  = BANK_NUM * T1W,
  localparam int BW  = BANK_NUM * T2W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          pred_valid,
  input  logic          pred_shift,
  input  logic          pred_taken,
  input  logic [CW-1:0] pred_idx,
  input  logic          redirect_valid,
  input  logic [CW-1:0] redirect_idx,
  input  logic          redirect_shift,
  input  logic          redirect_taken,
  output logic [IW-1:0] fold_idx,
  output logic [AW-1:0] fold_tag1,
  output logic [BW-1:0] fold_tag2,
  output logic [PW-1:0] ghr_ptr
);

  function automatic int max_len();
    int m;
    m = 0;
    for (int i = 0; i < BANK_NUM; i++)
      if (HIST_LEN[i] > m) m = HIST_LEN[i];
    return m;
  endfunction

  localparam int MAX_L = max_len();

  // GHR bits are never restored, so the ring must outlive every checkpoint.
  if (GHR_SIZE < MAX_L + CKPT_NUM) begin : g_bad_size
    $error("tage_hist: GHR_SIZE must be >= max(HIST_LEN)+CKPT_NUM");
  end
  if ((GHR_SIZE & (GHR_SIZE - 1)) != 0) begin : g_bad_ghr
    $error("tage_hist: GHR_SIZE must be a power of two");
  end
  if ((CKPT_NUM & (CKPT_NUM - 1)) != 0) begin : g_bad_ckpt
    $error("tage_hist: CKPT_NUM must be a power of two");
  end

  logic [GHR_SIZE-1:0] r_ghr;
  logic [PW-1:0]       r_ptr;
  logic [IW-1:0]       r_idx;
  logic [AW-1:0]       r_t1;
  logic [BW-1:0]       r_t2;

  logic [PW-1:0] r_ck_ptr [CKPT_NUM];
  logic [IW-1:0] r_ck_idx [CKPT_NUM];
  logic [AW-1:0] r_ck_t1  [CKPT_NUM];
  logic [BW-1:0] r_ck_t2  [CKPT_NUM];

  logic          w_redir;
  logic          w_pred;
  logic          w_upd;
  logic          w_shift;
  logic          w_bit;
  logic [PW-1:0] w_bptr;
  logic [IW-1:0] w_bidx;
  logic [AW-1:0] w_bt1;
  logic [BW-1:0] w_bt2;
  logic [IW-1:0] w_nidx;
  logic [AW-1:0] w_nt1;
  logic [BW-1:0] w_nt2;

  assign w_redir = redirect_valid;
  assign w_pred  = pred_valid & ~stall & ~redirect_valid;
  assign w_upd   = w_redir | w_pred;
  assign w_shift = w_redir ? redirect_shift : (w_pred & pred_shift);
  assign w_bit   = w_redir ? redirect_taken : pred_taken;

  // Redirect folds start from the checkpoint, pred folds from live state.
  assign w_bptr = w_redir ? r_ck_ptr[redirect_idx] : r_ptr;
  assign w_bidx = w_redir ? r_ck_idx[redirect_idx] : r_idx;
  assign w_bt1  = w_redir ? r_ck_t1[redirect_idx]  : r_t1;
  assign w_bt2  = w_redir ? r_ck_t2[redirect_idx]  : r_t2;

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    localparam int L  = HIST_LEN[b];
    localparam int SI = L % IDX_W;
    localparam int S1 = L % T1W;
    localparam int S2 = L % T2W;

    logic             w_o;
    logic [IDX_W-1:0] w_fi;
    logic [T1W-1:0]   w_f1;
    logic [T2W-1:0]   w_f2;

    assign w_o  = r_ghr[w_bptr - PW'(L)];
    assign w_fi = w_bidx[b*IDX_W +: IDX_W];
    assign w_f1 = w_bt1[b*T1W +: T1W];
    assign w_f2 = w_bt2[b*T2W +: T2W];

    assign w_nidx[b*IDX_W +: IDX_W] = w_shift ?
      ({w_fi[IDX_W-2:0], w_fi[IDX_W-1]} ^ IDX_W'(w_bit)
       ^ (IDX_W'(w_o) << SI)) : w_fi;
    assign w_nt1[b*T1W +: T1W] = w_shift ?
      ({w_f1[T1W-2:0], w_f1[T1W-1]} ^ T1W'(w_bit)
       ^ (T1W'(w_o) << S1)) : w_f1;
    assign w_nt2[b*T2W +: T2W] = w_shift ?
      ({w_f2[T2W-2:0], w_f2[T2W-1]} ^ T2W'(w_bit)
       ^ (T2W'(w_o) << S2)) : w_f2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= '0;
      r_ptr <= '0;
      r_idx <= '0;
      r_t1  <= '0;
      r_t2  <= '0;
      for (int i = 0; i < CKPT_NUM; i++) begin
        r_ck_ptr[i] <= '0;
        r_ck_idx[i] <= '0;
        r_ck_t1[i]  <= '0;
        r_ck_t2[i]  <= '0;
      end
    end else begin
      if (w_pred) begin
        r_ck_ptr[pred_idx] <= r_ptr;
        r_ck_idx[pred_idx] <= r_idx;
        r_ck_t1[pred_idx]  <= r_t1;
        r_ck_t2[pred_idx]  <= r_t2;
      end
      if (w_upd) begin
        r_ptr <= w_shift ? w_bptr + PW'(1) : w_bptr;
        r_idx <= w_nidx;
        r_t1  <= w_nt1;
        r_t2  <= w_nt2;
        if (w_shift) r_ghr[w_bptr] <= w_bit;
      end
    end
  end

  assign fold_idx  = r_idx;
  assign fold_tag1 = r_t1;
  assign fold_tag2 = r_t2;
  assign ghr_ptr   = r_ptr;

endmodule

// File: tb/tb_tage_hist.sv
// Directed bench for tage_hist against a full-history XOR-fold model.
module tb_tage_hist;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        pred_valid = 1'b0;
  logic        pred_shift = 1'b0;
  logic        pred_taken = 1'b0;
  logic [3:0]  pred_idx = '0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_idx = '0;
  logic        redirect_shift = 1'b0;
  logic        redirect_taken = 1'b0;
  logic [31:0] fold_idx;
  logic [47:0] fold_tag1;
  logic [39:0] fold_tag2;
  logic [6:0]  ghr_ptr;

  int checks = 0;
  int failures = 0;

  localparam int HL [4] = '{8, 16, 32, 64};

  logic [255:0] m_h;
  logic [6:0]   m_p;
  logic [255:0] ck_h [16];
  logic [6:0]   ck_p [16];
  logic         wrapped;

  tage_hist dut (
    .clk(clk), .rst(rst), .stall(stall),
    .pred_valid(pred_valid), .pred_shift(pred_shift),
    .pred_taken(pred_taken), .pred_idx(pred_idx),
    .redirect_valid(redirect_valid), .redirect_idx(redirect_idx),
    .redirect_shift(redirect_shift), .redirect_taken(redirect_taken),
    .fold_idx(fold_idx), .fold_tag1(fold_tag1),
    .fold_tag2(fold_tag2), .ghr_ptr(ghr_ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fold(logic [255:0] h, int L, int W);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < L; i++) f[i % W] ^= h[i];
    return f;
  endfunction

  function automatic logic [31:0] e_idx();
    logic [31:0] r;
    logic [15:0] f;
    for (int b = 0; b < 4; b++) begin
      f = fold(m_h, HL[b], 8);
      r[b*8 +: 8] = f[7:0];
    end
    return r;
  endfunction

  function automatic logic [47:0] e_t1();
    logic [47:0] r;
    logic [15:0] f;
    for (int b = 0; b < 4; b++) begin
      f = fold(m_h, HL[b], 12);
      r[b*12 +: 12] = f[11:0];
    end
    return r;
  endfunction

  function automatic logic [39:0] e_t2();
    logic [39:0] r;
    logic [15:0] f;
    for (int b = 0; b < 4; b++) begin
      f = fold(m_h, HL[b], 10);
      r[b*10 +: 10] = f[9:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_chk(input string tag);
    chk({tag, "_ptr"}, 64'(ghr_ptr), 64'(m_p));
    chk({tag, "_idx"}, 64'(fold_idx), 64'(e_idx()));
    chk({tag, "_t1"}, 64'(fold_tag1), 64'(e_t1()));
    chk({tag, "_t2"}, 64'(fold_tag2), 64'(e_t2()));
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_ptr"}, 64'(ghr_ptr), 64'd0);
    chk({tag, "_idx"}, 64'(fold_idx), 64'd0);
    chk({tag, "_t1"}, 64'(fold_tag1), 64'd0);
    chk({tag, "_t2"}, 64'(fold_tag2), 64'd0);
  endtask

  task automatic model_reset();
    m_h = '0;
    m_p = '0;
    for (int i = 0; i < 16; i++) begin
      ck_h[i] = '0;
      ck_p[i] = '0;
    end
  endtask

  task automatic m_shift(input logic b);
    m_h = {m_h[254:0], b};
    m_p = m_p + 7'd1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    zero_chk("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at a negedge; drives one cycle and checks after the edge.
  task automatic step(input logic st, input logic pv, input logic ps,
                      input logic pt, input logic [3:0] pi,
                      input logic rv, input logic [3:0] ri,
                      input logic rs, input logic rt);
    stall = st; pred_valid = pv; pred_shift = ps;
    pred_taken = pt; pred_idx = pi;
    redirect_valid = rv; redirect_idx = ri;
    redirect_shift = rs; redirect_taken = rt;
    @(posedge clk);
    if (rv) begin
      m_h = ck_h[ri];
      m_p = ck_p[ri];
      if (rs) m_shift(rt);
    end else if (pv && !st) begin
      ck_h[pi] = m_h;
      ck_p[pi] = m_p;
      if (ps) m_shift(pt);
    end
    #1;
    model_chk("step");
    @(negedge clk);
    stall = 1'b0; pred_valid = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // single taken shift
    step(0, 1, 1, 1, 4'd0, 0, 4'd0, 0, 0);
    chk("one_ptr", 64'(ghr_ptr), 64'd1);
    chk("one_idx", 64'(fold_idx), 64'h01010101);
    chk("one_t1", 64'(fold_tag1), 64'h001001001001);
    chk("one_t2", 64'(fold_tag2), 64'h0040100401);

    // nine taken shifts
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 1, 1, 1, 4'(i), 0, 4'd0, 0, 0);
    chk("nine_ptr", 64'(ghr_ptr), 64'd9);
    chk("nine_b0idx", 64'(fold_idx[7:0]), 64'hFF);
    chk("nine_b0t1", 64'(fold_tag1[11:0]), 64'h0FF);
    chk("nine_b1idx", 64'(fold_idx[15:8]), 64'hFE);

    // checkpoint restore plus corrected shift
    @(negedge clk);
    do_reset();
    step(0, 1, 1, 1, 4'd0, 0, 4'd0, 0, 0);
    step(0, 1, 1, 0, 4'd1, 0, 4'd0, 0, 0);
    step(0, 1, 1, 1, 4'd2, 0, 4'd0, 0, 0);
    step(0, 1, 1, 1, 4'd3, 0, 4'd0, 0, 0);
    step(0, 0, 0, 0, 4'd0, 1, 4'd2, 1, 0);
    chk("redir_ptr", 64'(ghr_ptr), 64'd3);
    chk("redir_b0idx", 64'(fold_idx[7:0]), 64'h04);

    // redirect beats pred; dropped pred leaves slot 5 unwritten
    step(0, 1, 1, 1, 4'd5, 1, 4'd2, 0, 0);
    chk("prio_ptr", 64'(ghr_ptr), 64'd2);
    chk("prio_b0idx", 64'(fold_idx[7:0]), 64'h02);
    step(0, 0, 0, 0, 4'd0, 1, 4'd5, 0, 0);
    chk("unw_ptr", 64'(ghr_ptr), 64'd0);
    chk("unw_idx", 64'(fold_idx), 64'd0);

    // stall holds preds, not redirects
    step(0, 1, 1, 1, 4'd1, 0, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, 4'd4, 0, 4'd0, 0, 0);
      chk("stall_ptr", 64'(ghr_ptr), 64'd1);
    end
    step(1, 1, 1, 0, 4'd4, 1, 4'd1, 1, 1);
    chk("stallredir_ptr", 64'(ghr_ptr), 64'd1);
    chk("stallredir_idx", 64'(fold_idx), 64'h01010101);

    // long random run across pointer wrap
    wrapped = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(0, 1, 1, 1'($urandom_range(0, 1)), 4'($urandom), 0, 4'd0, 0, 0);
      if (m_p == 7'd0) wrapped = 1'b1;
    end
    chk("wrap_seen", 64'(wrapped), 64'd1);
    chk("rand_nonzero", 64'(ghr_ptr), 64'd73);

    // asynchronous reset mid-cycle with a pred pending
    pred_valid = 1'b1; pred_shift = 1'b1; pred_taken = 1'b1;
    @(posedge clk);
    ck_h[pred_idx] = m_h;
    ck_p[pred_idx] = m_p;
    m_shift(1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    zero_chk("async");
    @(negedge clk);
    zero_chk("async_hold");
    rst = 1'b1;
    pred_valid = 1'b0;
    step(0, 1, 1, 1, 4'd0, 0, 4'd0, 0, 0);
    chk("post_rst_ptr", 64'(ghr_ptr), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
